// File: rtl/video_pkg.sv
// Shared video definitions: register indices, loader state encoding and sizing.
package video_pkg;

    localparam int NREGS  = 32;
    localparam int ADDR_W = 5;

    localparam logic [ADDR_W-1:0] BASE    = 5'd0;
    localparam logic [ADDR_W-1:0] LEFT    = 5'd1;
    localparam logic [ADDR_W-1:0] RIGHT   = 5'd2;
    localparam logic [ADDR_W-1:0] TOP     = 5'd3;
    localparam logic [ADDR_W-1:0] BOTTOM  = 5'd4;
    localparam logic [ADDR_W-1:0] MODE    = 5'd5;
    localparam logic [ADDR_W-1:0] PALETTE = 5'd16;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        COPY
    } loader_state_t;

endpackage

// File: rtl/video_reg_loader_if.sv
// Register-port bus: write strobe/index/data plus read strobe/data.
interface video_reg_loader_if #(
    parameter int ADDR_W = 5
);
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       wdata;
    logic              rd;
    logic [15:0]       rdata;

    modport master (output wr, addr, wdata, rd, input rdata);
    modport slave  (input wr, addr, wdata, rd, output rdata);
endinterface

// File: rtl/video_reg_loader_sync_fall_det.sv
// Synchroniser for the asynchronous active-low vsync plus a history flop for fall detection.
module sync_fall_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic reg_clk,
    input  logic nreset,
    input  logic vsync_in,
    output logic vs_fall
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   hist;

    always_ff @(posedge reg_clk) begin
        if (!nreset) begin
            sync <= '1;
            hist <= 1'b1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], vsync_in};
            hist <= sync[SYNC_STAGES-1];
        end
    end

    assign vs_fall = hist & ~sync[SYNC_STAGES-1];

endmodule

// File: rtl/video_reg_loader.sv
// Shadow register file streamed into the video controller on vsync after a commit.
// Build option VIDREG_DIRTY_EN: only entries written since their last copy are sent.
module video_reg_loader #(
    parameter int NREGS       = video_pkg::NREGS,
    parameter int ADDR_W      = video_pkg::ADDR_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      reg_clk,
    input  logic                      nreset,
    video_reg_loader_if.slave         cpu,
    video_reg_loader_if.master        ctrl,
    input  logic                      commit,
    input  logic                      vsync_in,
    output logic                      pending,
    output logic                      busy
);
    import video_pkg::*;

    loader_state_t     state, state_next;
    logic [ADDR_W-1:0] idx, idx_next;
    logic              rearm, rearm_next;
    logic              vs_fall;
    logic              last;
    logic              copy_en;
    logic [15:0]       shadow [NREGS];

    sync_fall_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .reg_clk  (reg_clk),
        .nreset   (nreset),
        .vsync_in (vsync_in),
        .vs_fall  (vs_fall)
    );

    assign last = (idx == ADDR_W'(NREGS - 1));

`ifdef VIDREG_DIRTY_EN
    logic [NREGS-1:0] dirty;

    assign copy_en = (state == COPY) && dirty[idx];

    // A CPU write to the entry being copied re-marks it, so it goes out next commit.
    always_ff @(posedge reg_clk) begin
        if (!nreset) begin
            dirty <= '0;
        end else begin
            if (copy_en) dirty[idx] <= 1'b0;
            if (cpu.wr)  dirty[cpu.addr] <= 1'b1;
        end
    end
`else
    assign copy_en = (state == COPY);
`endif

    always_comb begin
        state_next = state;
        idx_next   = idx;
        rearm_next = rearm;
        case (state)
            IDLE: if (commit) state_next = ARMED;
            ARMED: begin
                if (vs_fall) begin
                    state_next = COPY;
                    idx_next   = '0;
                end
            end
            COPY: begin
                idx_next = idx + 1'b1;
                if (commit) rearm_next = 1'b1;
                if (last) begin
                    state_next = (rearm || commit) ? ARMED : IDLE;
                    rearm_next = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge reg_clk) begin
        if (!nreset) begin
            state <= IDLE;
            idx   <= '0;
            rearm <= 1'b0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            rearm <= rearm_next;
        end
    end

    always_ff @(posedge reg_clk) begin
        if (!nreset) begin
            ctrl.wr    <= 1'b0;
            ctrl.addr  <= '0;
            ctrl.wdata <= '0;
        end else begin
            ctrl.wr <= copy_en;
            if (copy_en) begin
                ctrl.addr  <= idx;
                ctrl.wdata <= shadow[idx];
            end
        end
    end

    always_ff @(posedge reg_clk) begin
        if (!nreset) begin
            shadow    <= '{default: '0};
            cpu.rdata <= '0;
        end else begin
            if (cpu.wr) shadow[cpu.addr] <= cpu.wdata;
            if (cpu.rd) cpu.rdata <= shadow[cpu.addr];
        end
    end

    assign ctrl.rd = 1'b0;
    assign pending = (state != IDLE);
    assign busy    = (state == COPY);

endmodule
